mem_port_arbiter: RTL and testbench

- Shares one single-ported memory bus between the instruction fetch requester (IF, read-only) and the data requester (EX load/store path).
- Forwards the granted request to the bus with zero added latency.
- Tracks outstanding reads in a small ID FIFO so each read response returns to the requester that issued it.
- Sits between the core's IF/EX memory ports and the SoC memory bus.

---
 rtl/mem_port_arbiter_pkg.sv | 18 +
 rtl/mem_port_arbiter_if.sv | 50 +++++
 rtl/mem_port_arbiter_arb_id_fifo.sv | 67 ++++++
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/LSU memory port arbiter.
// Optional round-robin arbitration is selected with the MEM_ARB_RR_EN macro.
package mem_port_arbiter_pkg;

    typedef logic arb_id_t;

    localparam arb_id_t ARB_ID_IF  = 1'b0;
    localparam arb_id_t ARB_ID_LSU = 1'b1;

    localparam int unsigned XLEN_DEF      = 32;
    localparam int unsigned MAX_OUTST_DEF = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

endpackage : mem_port_arbiter_pkg

// File: rtl/mem_port_arbiter_if.sv
// Bundles the IF, LSU and SoC bus signals around the arbiter.
// slave = arbiter view, master = core requesters plus memory bus.
interface mem_port_arbiter_if #(
    parameter int unsigned XLEN = 32
) ();
    localparam int unsigned STRB_W = XLEN / 8;

    logic              ifu_req;
    logic [XLEN-1:0]   ifu_addr;
    logic              ifu_ready;
    logic              ifu_rvalid;
    logic [XLEN-1:0]   ifu_rdata;

    logic              lsu_req;
    logic              lsu_write;
    logic [STRB_W-1:0] lsu_wstrb;
    logic [XLEN-1:0]   lsu_addr;
    logic [XLEN-1:0]   lsu_wdata;
    logic              lsu_ready;
    logic              lsu_rvalid;
    logic [XLEN-1:0]   lsu_rdata;

    logic              bus_req;
    logic              bus_write;
    logic [STRB_W-1:0] bus_wstrb;
    logic [XLEN-1:0]   bus_addr;
    logic [XLEN-1:0]   bus_wdata;
    logic              bus_ready;
    logic              bus_rvalid;
    logic [XLEN-1:0]   bus_rdata;

    modport slave (
        input  ifu_req, ifu_addr,
        output ifu_ready, ifu_rvalid, ifu_rdata,
        input  lsu_req, lsu_write, lsu_wstrb, lsu_addr, lsu_wdata,
        output lsu_ready, lsu_rvalid, lsu_rdata,
        output bus_req, bus_write, bus_wstrb, bus_addr, bus_wdata,
        input  bus_ready, bus_rvalid, bus_rdata
    );

    modport master (
        output ifu_req, ifu_addr,
        input  ifu_ready, ifu_rvalid, ifu_rdata,
        output lsu_req, lsu_write, lsu_wstrb, lsu_addr, lsu_wdata,
        input  lsu_ready, lsu_rvalid, lsu_rdata,
        input  bus_req, bus_write, bus_wstrb, bus_addr, bus_wdata,
        output bus_ready, bus_rvalid, bus_rdata
    );

endinterface : mem_port_arbiter_if

// File: rtl/mem_port_arbiter_arb_id_fifo.sv
// Flop-based FIFO of requester IDs for reads in flight on the bus.
// full/empty come straight from the count register.
module arb_id_fifo #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule : arb_id_fifo

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between IF and LSU with zero-latency forwarding and in-order
// response routing. Define MEM_ARB_RR_EN for round-robin instead of LSU-over-IF priority.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned XLEN      = XLEN_DEF,
    parameter int unsigned MAX_OUTST = MAX_OUTST_DEF
) (
    input  logic                   clk,
    input  logic                   rst_b,
    mem_port_arbiter_if.slave      mp,
    output logic                   arb_err
);
    localparam int unsigned STRB_W = XLEN / 8;

    arb_state_e state_q, state_d;
    arb_id_t    lock_id_q, lock_id_d;
    logic       arb_err_q, arb_err_d;

    logic       gnt_valid;
    arb_id_t    gnt_id;
    logic       lsu_ok;
    logic       ifu_ok;
    logic       bus_req_c;
    logic       bus_write_c;
    logic       accept;
    logic       fifo_push;
    logic       fifo_pop;
    arb_id_t    fifo_head;
    logic       fifo_full;
    logic       fifo_empty;

`ifdef MEM_ARB_RR_EN
    arb_id_t    rr_last_q, rr_last_d;
`endif

    // Grant selection; a pending lock pins the grant until the bus accepts
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = ARB_ID_IF;
        lsu_ok    = mp.lsu_req & (mp.lsu_write | ~fifo_full);
        ifu_ok    = mp.ifu_req & ~fifo_full;
        if (!rst_b) begin
            gnt_valid = 1'b0;
        end else if (state_q == ST_LOCK) begin
            gnt_valid = 1'b1;
            gnt_id    = lock_id_q;
        end else if (lsu_ok && ifu_ok) begin
            gnt_valid = 1'b1;
`ifdef MEM_ARB_RR_EN
            gnt_id    = (rr_last_q == ARB_ID_LSU) ? ARB_ID_IF : ARB_ID_LSU;
`else
            gnt_id    = ARB_ID_LSU;
`endif
        end else if (lsu_ok) begin
            gnt_valid = 1'b1;
            gnt_id    = ARB_ID_LSU;
        end else if (ifu_ok) begin
            gnt_valid = 1'b1;
            gnt_id    = ARB_ID_IF;
        end
    end

    // Bus forwarding mux; IF fetches never carry write payload
    always_comb begin
        bus_req_c    = 1'b0;
        bus_write_c  = 1'b0;
        mp.bus_wstrb = '0;
        mp.bus_addr  = '0;
        mp.bus_wdata = '0;
        if (gnt_valid) begin
            if (gnt_id == ARB_ID_LSU) begin
                bus_req_c    = mp.lsu_req;
                bus_write_c  = mp.lsu_write;
                mp.bus_wstrb = mp.lsu_wstrb;
                mp.bus_addr  = mp.lsu_addr;
                mp.bus_wdata = mp.lsu_wdata;
            end else begin
                bus_req_c    = mp.ifu_req;
                mp.bus_addr  = mp.ifu_addr;
            end
        end
    end

    assign mp.bus_req   = bus_req_c;
    assign mp.bus_write = bus_write_c;
    assign accept       = bus_req_c & mp.bus_ready;
    assign mp.ifu_ready = accept & (gnt_id == ARB_ID_IF);
    assign mp.lsu_ready = accept & (gnt_id == ARB_ID_LSU);

    assign fifo_push = accept & ~bus_write_c;
    assign fifo_pop  = mp.bus_rvalid & ~fifo_empty;

    assign mp.ifu_rvalid = fifo_pop & (fifo_head == ARB_ID_IF);
    assign mp.lsu_rvalid = fifo_pop & (fifo_head == ARB_ID_LSU);
    assign mp.ifu_rdata  = mp.bus_rdata;
    assign mp.lsu_rdata  = mp.bus_rdata;
    assign arb_err       = arb_err_q;

    arb_id_fifo #(
        .WIDTH (1),
        .DEPTH (MAX_OUTST)
    ) u_id_fifo (
        .clk       (clk),
        .rst_b     (rst_b),
        .push      (fifo_push),
        .push_data (gnt_id),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Lock FSM next state and sticky error
    always_comb begin
        state_d   = ST_IDLE;
        lock_id_d = lock_id_q;
        arb_err_d = arb_err_q | (mp.bus_rvalid & fifo_empty);
        if (bus_req_c && !mp.bus_ready) begin
            state_d   = ST_LOCK;
            lock_id_d = gnt_id;
        end
    end

`ifdef MEM_ARB_RR_EN
    always_comb begin
        rr_last_d = accept ? gnt_id : rr_last_q;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            rr_last_q <= ARB_ID_IF;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= ST_IDLE;
            lock_id_q <= ARB_ID_IF;
            arb_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
            arb_err_q <= arb_err_d;
        end
    end

    if (STRB_W * 8 != XLEN) begin : g_bad_xlen
        $error("XLEN must be a multiple of 8");
    end

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, contention, lock, routing, full, spurious response.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic clk;
    logic rst_b;
    logic arb_err;
    int   n_tests;
    int   n_fail;

    mem_port_arbiter_if #(.XLEN(32)) bif ();

    mem_port_arbiter #(
        .XLEN      (32),
        .MAX_OUTST (2)
    ) dut (
        .clk     (clk),
        .rst_b   (rst_b),
        .mp      (bif),
        .arb_err (arb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        bif.ifu_req    = 1'b0;
        bif.ifu_addr   = '0;
        bif.lsu_req    = 1'b0;
        bif.lsu_write  = 1'b0;
        bif.lsu_wstrb  = '0;
        bif.lsu_addr   = '0;
        bif.lsu_wdata  = '0;
        bif.bus_ready  = 1'b0;
        bif.bus_rvalid = 1'b0;
        bif.bus_rdata  = '0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        idle_inputs();
        rst_b = 1'b1;
        #1 rst_b = 1'b0;

        // Reset state: grant suppressed even with a request present
        bif.lsu_req  = 1'b1;
        bif.lsu_addr = 32'h40;
        bif.bus_ready = 1'b1;
        settle();
        chk("rst_bus_req", 32'(bif.bus_req), 32'h0);
        chk("rst_lsu_ready", 32'(bif.lsu_ready), 32'h0);
        chk("rst_arb_err", 32'(arb_err), 32'h0);
        tick();
        tick();

        // 1. Reset mid-handshake
        rst_b = 1'b1;
        bif.bus_ready = 1'b0;
        settle();
        chk("t1_bus_req", 32'(bif.bus_req), 32'h1);
        chk("t1_bus_addr", bif.bus_addr, 32'h40);
        chk("t1_lsu_ready_stall", 32'(bif.lsu_ready), 32'h0);
        tick();
        bif.ifu_req  = 1'b1;
        bif.ifu_addr = 32'h100;
        settle();
        chk("t1_locked_addr", bif.bus_addr, 32'h40);
        rst_b = 1'b0;
        settle();
        chk("t1_async_bus_req", 32'(bif.bus_req), 32'h0);
        chk("t1_async_ifu_ready", 32'(bif.ifu_ready), 32'h0);
        tick();
        rst_b = 1'b1;
        bif.ifu_req   = 1'b0;
        bif.bus_ready = 1'b1;
        settle();
        chk("t1_regrant_ready", 32'(bif.lsu_ready), 32'h1);
        chk("t1_regrant_addr", bif.bus_addr, 32'h40);
        tick();
        bif.lsu_req    = 1'b0;
        bif.bus_rvalid = 1'b1;
        bif.bus_rdata  = 32'h1111;
        settle();
        chk("t1_lsu_rvalid", 32'(bif.lsu_rvalid), 32'h1);
        chk("t1_ifu_rvalid", 32'(bif.ifu_rvalid), 32'h0);
        chk("t1_ifu_rdata_fanout", bif.ifu_rdata, 32'h1111);
        tick();
        bif.bus_rvalid = 1'b0;
        settle();
        chk("t1_arb_err", 32'(arb_err), 32'h0);

        // 2. Contention: LSU write vs IF read, bus always ready
        bif.ifu_req   = 1'b1;
        bif.ifu_addr  = 32'h100;
        bif.lsu_req   = 1'b1;
        bif.lsu_write = 1'b1;
        bif.lsu_addr  = 32'h300;
        bif.lsu_wdata = 32'hDEAD;
        bif.lsu_wstrb = 4'hF;
        for (int c = 0; c < 3; c++) begin
            settle();
`ifdef MEM_ARB_RR_EN
            // rr_last is LSU after the previous load, so IF wins first
            chk("t2_rr_ifu_ready", 32'(bif.ifu_ready), (c % 2 == 0) ? 32'h1 : 32'h0);
            chk("t2_rr_lsu_ready", 32'(bif.lsu_ready), (c % 2 == 0) ? 32'h0 : 32'h1);
`else
            chk("t2_lsu_ready", 32'(bif.lsu_ready), 32'h1);
            chk("t2_ifu_ready", 32'(bif.ifu_ready), 32'h0);
            chk("t2_bus_write", 32'(bif.bus_write), 32'h1);
            chk("t2_bus_wdata", bif.bus_wdata, 32'hDEAD);
`endif
            tick();
        end
        idle_inputs();
`ifdef MEM_ARB_RR_EN
        for (int r = 0; r < 2; r++) begin
            bif.bus_rvalid = 1'b1;
            settle();
            chk("t2_rr_drain", 32'(bif.ifu_rvalid), 32'h1);
            tick();
        end
        bif.bus_rvalid = 1'b0;
`endif

        // 3. Lock: IF held on a stalled bus while LSU arrives
        bif.ifu_req  = 1'b1;
        bif.ifu_addr = 32'h100;
        settle();
        chk("t3_if_addr", bif.bus_addr, 32'h100);
        chk("t3_if_write", 32'(bif.bus_write), 32'h0);
        chk("t3_if_wstrb", 32'(bif.bus_wstrb), 32'h0);
        tick();
        bif.lsu_req   = 1'b1;
        bif.lsu_write = 1'b1;
        bif.lsu_addr  = 32'h300;
        bif.lsu_wdata = 32'h1234;
        bif.lsu_wstrb = 4'h3;
        settle();
        chk("t3_lock_addr_c1", bif.bus_addr, 32'h100);
        chk("t3_lock_lsu_ready", 32'(bif.lsu_ready), 32'h0);
        chk("t3_lock_wdata", bif.bus_wdata, 32'h0);
        tick();
        settle();
        chk("t3_lock_addr_c2", bif.bus_addr, 32'h100);
        tick();
        bif.bus_ready = 1'b1;
        settle();
        chk("t3_release_ifu_ready", 32'(bif.ifu_ready), 32'h1);
        chk("t3_release_addr", bif.bus_addr, 32'h100);
        chk("t3_release_lsu_ready", 32'(bif.lsu_ready), 32'h0);
        tick();
        bif.ifu_req = 1'b0;
        settle();
        chk("t3_lsu_next_ready", 32'(bif.lsu_ready), 32'h1);
        chk("t3_lsu_next_addr", bif.bus_addr, 32'h300);
        chk("t3_lsu_next_wstrb", 32'(bif.bus_wstrb), 32'h3);
        tick();
        bif.lsu_req    = 1'b0;
        bif.lsu_write  = 1'b0;
        bif.bus_rvalid = 1'b1;
        bif.bus_rdata  = 32'h5555;
        settle();
        chk("t3_resp_ifu_rvalid", 32'(bif.ifu_rvalid), 32'h1);
        tick();
        bif.bus_rvalid = 1'b0;

        // 4. Routing: IF read then LSU read, in-order responses
        bif.ifu_req  = 1'b1;
        bif.ifu_addr = 32'h100;
        settle();
        chk("t4_ifu_ready", 32'(bif.ifu_ready), 32'h1);
        tick();
        bif.ifu_req  = 1'b0;
        bif.lsu_req  = 1'b1;
        bif.lsu_addr = 32'h200;
        settle();
        chk("t4_lsu_ready", 32'(bif.lsu_ready), 32'h1);
        chk("t4_lsu_addr", bif.bus_addr, 32'h200);
        tick();
        bif.lsu_req    = 1'b0;
        bif.bus_rvalid = 1'b1;
        bif.bus_rdata  = 32'hAAAA;
        settle();
        chk("t4_r1_ifu_rvalid", 32'(bif.ifu_rvalid), 32'h1);
        chk("t4_r1_lsu_rvalid", 32'(bif.lsu_rvalid), 32'h0);
        chk("t4_r1_ifu_rdata", bif.ifu_rdata, 32'hAAAA);
        tick();
        bif.bus_rdata = 32'hBBBB;
        settle();
        chk("t4_r2_lsu_rvalid", 32'(bif.lsu_rvalid), 32'h1);
        chk("t4_r2_ifu_rvalid", 32'(bif.ifu_rvalid), 32'h0);
        chk("t4_r2_lsu_rdata", bif.lsu_rdata, 32'hBBBB);
        tick();
        bif.bus_rvalid = 1'b0;

        // 5. Full: two reads outstanding block a third, writes still pass
        bif.ifu_req  = 1'b1;
        bif.ifu_addr = 32'h100;
        settle();
        chk("t5_rd1_ready", 32'(bif.ifu_ready), 32'h1);
        tick();
        bif.ifu_req  = 1'b0;
        bif.lsu_req  = 1'b1;
        bif.lsu_addr = 32'h200;
        settle();
        chk("t5_rd2_ready", 32'(bif.lsu_ready), 32'h1);
        tick();
        bif.lsu_req  = 1'b0;
        bif.ifu_req  = 1'b1;
        bif.ifu_addr = 32'h104;
        settle();
        chk("t5_full_ifu_ready", 32'(bif.ifu_ready), 32'h0);
        chk("t5_full_bus_req", 32'(bif.bus_req), 32'h0);
        tick();
        bif.lsu_req   = 1'b1;
        bif.lsu_write = 1'b1;
        bif.lsu_addr  = 32'h300;
        settle();
        chk("t5_full_wr_ready", 32'(bif.lsu_ready), 32'h1);
        chk("t5_full_wr_ifu_ready", 32'(bif.ifu_ready), 32'h0);
        tick();
        bif.lsu_req    = 1'b0;
        bif.lsu_write  = 1'b0;
        bif.bus_rvalid = 1'b1;
        bif.bus_rdata  = 32'hC;
        settle();
        chk("t5_pop_ifu_rvalid", 32'(bif.ifu_rvalid), 32'h1);
        chk("t5_pop_same_cycle_blocked", 32'(bif.ifu_ready), 32'h0);
        tick();
        bif.bus_rvalid = 1'b0;
        settle();
        chk("t5_unblocked_ready", 32'(bif.ifu_ready), 32'h1);
        chk("t5_unblocked_addr", bif.bus_addr, 32'h104);
        tick();
        bif.ifu_req    = 1'b0;
        bif.bus_rvalid = 1'b1;
        bif.bus_rdata  = 32'hD;
        settle();
        chk("t5_drain1_lsu_rvalid", 32'(bif.lsu_rvalid), 32'h1);
        tick();
        bif.bus_rdata = 32'hE;
        settle();
        chk("t5_drain2_ifu_rvalid", 32'(bif.ifu_rvalid), 32'h1);
        tick();
        bif.bus_rvalid = 1'b0;

        // 6. Spurious response with nothing outstanding
        bif.bus_rvalid = 1'b1;
        bif.bus_rdata  = 32'h77;
        settle();
        chk("t6_no_ifu_rvalid", 32'(bif.ifu_rvalid), 32'h0);
        chk("t6_no_lsu_rvalid", 32'(bif.lsu_rvalid), 32'h0);
        chk("t6_err_not_yet", 32'(arb_err), 32'h0);
        tick();
        bif.bus_rvalid = 1'b0;
        settle();
        chk("t6_err_set", 32'(arb_err), 32'h1);
        tick();
        tick();
        chk("t6_err_sticky", 32'(arb_err), 32'h1);
        bif.lsu_req  = 1'b1;
        bif.lsu_addr = 32'h400;
        settle();
        chk("t6_after_lsu_ready", 32'(bif.lsu_ready), 32'h1);
        tick();
        bif.lsu_req    = 1'b0;
        bif.bus_rvalid = 1'b1;
        bif.bus_rdata  = 32'hF;
        settle();
        chk("t6_after_lsu_rvalid", 32'(bif.lsu_rvalid), 32'h1);
        chk("t6_after_ifu_rvalid", 32'(bif.ifu_rvalid), 32'h0);
        tick();
        bif.bus_rvalid = 1'b0;
        settle();
        chk("t6_err_final", 32'(arb_err), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mem_port_arbiter
